// File: rtl/button_pulser_pkg.sv
// Shared types and helpers for the button conditioning pipeline.
package button_pulser_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StHeld,
    StRelDb
  } chan_state_e;

  // Counter width that holds the larger of the debounce and repeat-delay terminal counts.
  function automatic int unsigned cnt_width(input int unsigned debounce_cycles,
                                            input int unsigned repeat_delay);
    int unsigned max_val;
    max_val = (debounce_cycles > repeat_delay) ? debounce_cycles : repeat_delay;
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/button_pulser_if.sv
// Button vector bundle: raw levels in, command pulses and debounced levels out.
interface button_pulser_if #(
  parameter int unsigned NUM_BUTTONS = 2
);

  logic [NUM_BUTTONS-1:0] button_in;
  logic [NUM_BUTTONS-1:0] press_pulse;
  logic [NUM_BUTTONS-1:0] level;

  modport master (
    output button_in,
    input  press_pulse,
    input  level
  );

  modport slave (
    input  button_in,
    output press_pulse,
    output level
  );

endinterface

// File: rtl/button_pulser_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and optional hold-to-repeat.
module button_pulser_channel
  import button_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_button,
  output logic o_pulse,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RptLast   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RptReload = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [1:0]       r_sync;
  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rpt;
  logic             r_level;
  logic             r_pulse;
  logic             w_s;

  assign w_s = r_sync[1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b00;
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rpt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_button};
      r_pulse <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_s) begin
            r_state <= StPressDb;
            r_cnt   <= CntOne;
          end
        end
        StPressDb: begin
          if (!w_s) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else if (r_cnt == DbLast) begin
            r_state <= StHeld;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
            r_rpt   <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        StHeld: begin
          if (!w_s) begin
            r_state <= StRelDb;
            r_cnt   <= CntOne;
          end else if (REPEAT_EN != 0) begin
            // After the first repeat, reloading keeps later pulses REPEAT_PERIOD apart.
            if (r_rpt == RptLast) begin
              r_pulse <= 1'b1;
              r_rpt   <= RptReload;
            end else begin
              r_rpt <= sat_inc(r_rpt);
            end
          end
        end
        StRelDb: begin
          if (w_s) begin
            r_state <= StHeld;
            r_cnt   <= '0;
          end else if (r_cnt == DbLast) begin
            r_state <= StIdle;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

// File: rtl/button_pulser.sv
// Top level: one independent conditioning channel per push-button.
module button_pulser
  import button_pulser_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic              clock,
  input  logic              reset_n,
  button_pulser_if.slave    bus
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY);

  logic [NUM_BUTTONS-1:0] w_pulse;
  logic [NUM_BUTTONS-1:0] w_level;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_pulser_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CntW)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_button (bus.button_in[g]),
      .o_pulse  (w_pulse[g]),
      .o_level  (w_level[g])
    );
  end

  assign bus.press_pulse = w_pulse;
  assign bus.level       = w_level;

endmodule
